// File: rtl/alu_operand_stage.sv
// alu_operand_stage: operand fetch / issue stage in front of the ALU.
// Resolves op2 from an immediate or a one-cycle-latency RAM read, forwards a
// same-cycle accumulator write into op1, and strobes aluEn once per instruction.
`ifndef aluOpcodeLen
`define aluOpcodeLen 4
`endif

module alu_operand_stage #(
   parameter int OPC_W  = `aluOpcodeLen,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              instValid,
   output logic              instReady,
   input  logic [OPC_W-1:0]  instOpcode,
   input  logic              instImm,
   input  logic [7:0]        instOperand,
   output logic              ramRdEn,
   output logic [ADDR_W-1:0] ramAddr,
   input  logic [7:0]        ramData,
   input  logic [7:0]        accIn,
   input  logic              accWrEn,
   input  logic [7:0]        accWrData,
   output logic [OPC_W-1:0]  aluOpcode,
   output logic [7:0]        op1,
   output logic [7:0]        op2,
   output logic              aluEn
);

   typedef enum logic [1:0] {IDLE, READ, CAPT, ISSUE} state_t;

   state_t              state_q, state_d;
   logic [OPC_W-1:0]    opc_lat_q, opc_lat_d;
   logic [OPC_W-1:0]    alu_opc_q, alu_opc_d;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic                ram_rd_en_q, ram_rd_en_d;
   logic [7:0]          op2_q, op2_d;
   logic [7:0]          op1_hold_q, op1_hold_d;
   logic                accept;
   logic [7:0]          acc_fwd;

   // Truncate or zero-extend the 8-bit operand to the RAM address width.
   function automatic logic [ADDR_W-1:0] to_addr(input logic [7:0] v);
      logic [ADDR_W-1:0] r;
      r = '0;
      for (int i = 0; i < ADDR_W; i++) begin
         if (i < 8) r[i] = v[i];
      end
      return r;
   endfunction

   // Handshake, strobe and op1 decode; everything is held quiet while in reset.
   always_comb begin
      instReady = !reset && !flush && ((state_q == IDLE) || (state_q == ISSUE));
      aluEn     = !reset && (state_q == ISSUE);
      accept    = instValid && instReady;
      acc_fwd   = accWrEn ? accWrData : accIn;
      if (reset)                 op1 = 8'h00;
      else if (state_q == ISSUE) op1 = acc_fwd;
      else                       op1 = op1_hold_q;
   end

   // Next-state and next-register computation.
   always_comb begin
      state_d     = state_q;
      opc_lat_d   = opc_lat_q;
      alu_opc_d   = alu_opc_q;
      ram_addr_d  = ram_addr_q;
      ram_rd_en_d = 1'b0;
      op2_d       = op2_q;
      op1_hold_d  = op1_hold_q;

      case (state_q)
         IDLE:  state_d = IDLE;
         READ:  state_d = CAPT;
         CAPT: begin
            op2_d     = ramData;
            alu_opc_d = opc_lat_q;
            state_d   = ISSUE;
         end
         ISSUE: begin
            op1_hold_d = acc_fwd;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A new instruction accepted in IDLE or ISSUE overrides the default path.
      if (accept) begin
         opc_lat_d = instOpcode;
         if (instImm) begin
            op2_d     = instOperand;
            alu_opc_d = instOpcode;
            state_d   = ISSUE;
         end else begin
            ram_addr_d  = to_addr(instOperand);
            ram_rd_en_d = 1'b1;
            state_d     = READ;
         end
      end

      // Flush drops the in-flight instruction but leaves operand registers intact.
      if (flush) begin
         state_d     = IDLE;
         ram_rd_en_d = 1'b0;
         op2_d       = op2_q;
         alu_opc_d   = alu_opc_q;
         op1_hold_d  = op1_hold_q;
      end
   end

   // State and operand registers; reset clears everything visible at the ports.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         opc_lat_q   <= '0;
         alu_opc_q   <= '0;
         ram_addr_q  <= '0;
         ram_rd_en_q <= 1'b0;
         op2_q       <= '0;
         op1_hold_q  <= '0;
      end else begin
         state_q     <= state_d;
         opc_lat_q   <= opc_lat_d;
         alu_opc_q   <= alu_opc_d;
         ram_addr_q  <= ram_addr_d;
         ram_rd_en_q <= ram_rd_en_d;
         op2_q       <= op2_d;
         op1_hold_q  <= op1_hold_d;
      end
   end

   assign ramRdEn   = ram_rd_en_q;
   assign ramAddr   = ram_addr_q;
   assign op2       = op2_q;
   assign aluOpcode = alu_opc_q;

endmodule
